// File: rtl/win_led_sequencer.sv
// win_led_sequencer: latches the win code from the win detector and plays it on
// the RGB result LED. The LED flashes FLASH_COUNT times in the winner's colour
// and then holds steady until a new_game pulse returns the block to idle.
module win_led_sequencer #(
    parameter int TICK_DIV    = 5_000_000,
    parameter int ON_TICKS    = 5,
    parameter int OFF_TICKS   = 5,
    parameter int FLASH_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] detect_win,
    input  logic       new_game,
    output logic [2:0] led_out,
    output logic       busy,
    output logic [1:0] result
);

    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = ($clog2(MAX_TICKS + 1) > 0) ? $clog2(MAX_TICKS + 1) : 1;
    localparam int FW = ($clog2(FLASH_COUNT + 1) > 0) ? $clog2(FLASH_COUNT + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
    localparam logic [FW-1:0] FLASH_DONE = FW'(FLASH_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        FLASH_ON,
        FLASH_OFF,
        HOLD
    } state_t;

    state_t        state;
    logic          armed;
    logic [PW-1:0] prescaler;
    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] flash_cnt;
    logic          tick;
    logic [FW-1:0] flash_next;

    // Fixed colour map from win code to RGB drive
    function automatic logic [2:0] colour_of(input logic [1:0] code);
        case (code)
            2'b01:   colour_of = 3'b100;
            2'b10:   colour_of = 3'b010;
            2'b11:   colour_of = 3'b001;
            default: colour_of = 3'b000;
        endcase
    endfunction

    // Timing tick fires on the last prescaler count, only while flashing
    always_comb begin
        tick       = ((state == FLASH_ON) || (state == FLASH_OFF)) && (prescaler == PRE_LAST);
        flash_next = flash_cnt + FW'(1);
    end

    // Sequencer FSM with registered LED, busy and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b1;
            prescaler <= '0;
            tick_cnt  <= '0;
            flash_cnt <= '0;
            led_out   <= 3'b000;
            busy      <= 1'b0;
            result    <= 2'b00;
        end else if (new_game) begin
            state     <= IDLE;
            armed     <= 1'b0;
            prescaler <= '0;
            tick_cnt  <= '0;
            flash_cnt <= '0;
            led_out   <= 3'b000;
            busy      <= 1'b0;
            result    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    prescaler <= '0;
                    tick_cnt  <= '0;
                    flash_cnt <= '0;
                    led_out   <= 3'b000;
                    busy      <= 1'b0;
                    result    <= 2'b00;
                    if (detect_win == 2'b00) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state   <= FLASH_ON;
                        result  <= detect_win;
                        led_out <= colour_of(detect_win);
                        busy    <= 1'b1;
                    end
                end
                FLASH_ON: begin
                    prescaler <= tick ? '0 : prescaler + PW'(1);
                    if (tick) begin
                        if (tick_cnt == ON_LAST) begin
                            state    <= FLASH_OFF;
                            tick_cnt <= '0;
                            led_out  <= 3'b000;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                FLASH_OFF: begin
                    prescaler <= tick ? '0 : prescaler + PW'(1);
                    if (tick) begin
                        if (tick_cnt == OFF_LAST) begin
                            tick_cnt  <= '0;
                            flash_cnt <= flash_next;
                            led_out   <= colour_of(result);
                            if (flash_next == FLASH_DONE) begin
                                state <= HOLD;
                                busy  <= 1'b0;
                            end else begin
                                state <= FLASH_ON;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                HOLD: begin
                    prescaler <= '0;
                    tick_cnt  <= '0;
                    led_out   <= colour_of(result);
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_led_sequencer.sv
// tb_win_led_sequencer: directed scenarios for the result LED sequencer with
// TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, FLASH_COUNT=2 (8 on, 4 off, 24 busy).
module tb_win_led_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] detect_win;
    logic       new_game;
    logic [2:0] led_out;
    logic       busy;
    logic [1:0] result;

    int tests;
    int fails;

    win_led_sequencer #(
        .TICK_DIV(4),
        .ON_TICKS(2),
        .OFF_TICKS(1),
        .FLASH_COUNT(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .detect_win(detect_win),
        .new_game(new_game),
        .led_out(led_out),
        .busy(busy),
        .result(result)
    );

    // Free-running 10-unit clock; all driving and sampling happens on negedges
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected LED for cycle i after the trigger edge (i=0 is right after it)
    function automatic logic [2:0] exp_led(input int i, input logic [2:0] col);
        if (i < 8 || (i >= 12 && i < 20) || i >= 24) exp_led = col;
        else exp_led = 3'b000;
    endfunction

    // Pulse reset and leave the block idle with inputs quiet
    task automatic do_reset();
        detect_win = 2'b00;
        new_game   = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        detect_win = 2'b00;
        new_game   = 1'b0;
        rst_n      = 1'b0;
        #1;
        tests++;
        if ({led_out, busy, result} !== 6'b000_0_00) begin
            fails++;
            $display("[TB] FAIL reset_values: got led=%b busy=%b result=%b, want 000 0 00", led_out, busy, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({led_out, busy, result} !== 6'b000_0_00) begin
                fails++;
                $display("[TB] FAIL idle_quiet: got led=%b busy=%b result=%b, want 000 0 00", led_out, busy, result);
            end
        end
    endtask

    task automatic test_player1();
        do_reset();
        detect_win = 2'b01;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            tests++;
            if (led_out !== exp_led(i, 3'b100) || busy !== (i < 24) || result !== 2'b01) begin
                fails++;
                $display("[TB] FAIL p1_cycle%0d: got led=%b busy=%b result=%b, want %b %b 01",
                         i, led_out, busy, result, exp_led(i, 3'b100), (i < 24));
            end
        end
    endtask

    task automatic test_draw_new_game();
        do_reset();
        detect_win = 2'b11;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            tests++;
            if (led_out !== exp_led(i, 3'b001) || busy !== (i < 24) || result !== 2'b11) begin
                fails++;
                $display("[TB] FAIL draw_cycle%0d: got led=%b busy=%b result=%b, want %b %b 11",
                         i, led_out, busy, result, exp_led(i, 3'b001), (i < 24));
            end
        end
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        tests++;
        if ({led_out, busy, result} !== 6'b000_0_00) begin
            fails++;
            $display("[TB] FAIL draw_new_game: got led=%b busy=%b result=%b, want 000 0 00", led_out, busy, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({led_out, busy, result} !== 6'b000_0_00) begin
                fails++;
                $display("[TB] FAIL draw_no_retrigger%0d: got led=%b busy=%b result=%b, want 000 0 00", i, led_out, busy, result);
            end
        end
        detect_win = 2'b00;
        @(negedge clk);
        detect_win = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (led_out !== exp_led(i, 3'b010) || busy !== 1'b1 || result !== 2'b10) begin
                fails++;
                $display("[TB] FAIL p2_cycle%0d: got led=%b busy=%b result=%b, want %b 1 10",
                         i, led_out, busy, result, exp_led(i, 3'b010));
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        detect_win = 2'b01;
        repeat (15) @(negedge clk);
        tests++;
        if (led_out !== 3'b100 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL abort_second_on: got led=%b busy=%b, want 100 1", led_out, busy);
        end
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        tests++;
        if ({led_out, busy, result} !== 6'b000_0_00) begin
            fails++;
            $display("[TB] FAIL abort_idle: got led=%b busy=%b result=%b, want 000 0 00", led_out, busy, result);
        end
        repeat (3) @(negedge clk);
        tests++;
        if ({led_out, busy, result} !== 6'b000_0_00) begin
            fails++;
            $display("[TB] FAIL abort_no_trigger: got led=%b busy=%b result=%b, want 000 0 00", led_out, busy, result);
        end
    endtask

    task automatic test_input_change();
        do_reset();
        detect_win = 2'b01;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 9) detect_win = 2'b10;
            tests++;
            if (led_out !== exp_led(i, 3'b100) || busy !== (i < 24) || result !== 2'b01) begin
                fails++;
                $display("[TB] FAIL change_cycle%0d: got led=%b busy=%b result=%b, want %b %b 01",
                         i, led_out, busy, result, exp_led(i, 3'b100), (i < 24));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        detect_win = 2'b01;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({led_out, busy, result} !== 6'b000_0_00) begin
            fails++;
            $display("[TB] FAIL async_reset: got led=%b busy=%b result=%b, want 000 0 00", led_out, busy, result);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            tests++;
            if (led_out !== exp_led(i, 3'b100) || busy !== (i < 24) || result !== 2'b01) begin
                fails++;
                $display("[TB] FAIL restart_cycle%0d: got led=%b busy=%b result=%b, want %b %b 01",
                         i, led_out, busy, result, exp_led(i, 3'b100), (i < 24));
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_player1();
        test_draw_new_game();
        test_abort();
        test_input_change();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/win_led_sequencer.md
# win_led_sequencer

Sequencer for the RGB result LED of the 3-in-a-row game. It latches the 2-bit win code from the win detector and plays a fixed presentation on the 3-bit LED: a timed flash sequence in the winner's colour, then a steady hold. The hold lasts until the game logic issues a new-game pulse. It sits between the win-detection logic and the board RGB LED pins.

## Interface
- TICK_DIV, default 5_000_000: clock cycles per timing tick (50 ms at 100 MHz). Must be ≥1.
- ON_TICKS, default 5: ticks the LED is lit per flash. Must be ≥1.
- OFF_TICKS, default 5: ticks the LED is dark per flash. Must be ≥1.
- FLASH_COUNT, default 3: number of ON+OFF flashes before hold. Must be ≥1.
- clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  reset, asynchronous and active-low.
- detect_win  input  2  win code: 00 none, 01 player 1, 10 player 2, 11 draw.
- new_game  input  1  single-cycle pulse that ends the presentation.
- led_out  output  3  registered RGB drive.
- busy  output  1  registered; 1 while the flash sequence runs.
- result  output  2  registered latched win code; 00 when none is latched.

## Operation
- The colour map is fixed, applied to the latched result: 01→100, 10→010, 11→001, 00→000.
- The FSM has four states: IDLE, FLASH_ON, FLASH_OFF, HOLD.
- An internal `armed` flag is set on reset. It is set in IDLE whenever detect_win==00 is sampled, and cleared by new_game.
- **IDLE.** led_out=000, busy=0, result=00.
  - Trigger: detect_win≠00 and armed=1.
  - On trigger: latch result=detect_win, clear the prescaler, tick counter and flash counter, then go to FLASH_ON.
- **FLASH_ON.** led_out=colour, busy=1. After ON_TICKS ticks, go to FLASH_OFF.
- **FLASH_OFF.** led_out=000, busy=1. After OFF_TICKS ticks:
  - increment the flash counter;
  - if it equals FLASH_COUNT, go to HOLD; otherwise go to FLASH_ON.
- **HOLD.** led_out=colour, busy=0. The state persists indefinitely.
- **new_game.** In any state, the next edge forces IDLE, led_out=000, busy=0, result=00, armed=0, and clears all counters.
  - new_game has priority over a trigger in the same cycle.
  - After new_game, detect_win must read 00 for at least one cycle before a new trigger is accepted. This prevents a stale win from replaying.
- detect_win is ignored outside IDLE; result stays latched.
- **Prescaler.** Counts 0..TICK_DIV-1 and wraps. It emits a one-cycle tick when its value is TICK_DIV-1.
  - It runs only in FLASH_ON and FLASH_OFF; it is held at 0 in IDLE and HOLD.
  - The tick counter clears on every phase change.
- **Counter widths.** $clog2(TICK_DIV), $clog2(max(ON_TICKS,OFF_TICKS)+1) and $clog2(FLASH_COUNT+1), each at least 1 bit. No overflow is possible within the legal parameter range.

## Timing
- **Reset values.** led_out=000, busy=0, result=00, state=IDLE, armed=1, all counters 0.
  - Assertion takes effect immediately, independent of clk, including mid-sequence.
  - After deassertion, the block triggers on the first edge at which detect_win≠00.
- **Trigger latency.** Trigger sampled at edge k: led_out=colour, busy=1 and result are valid after edge k. No additional pipeline stage.
- **Phase lengths.** FLASH_ON lasts exactly ON_TICKS×TICK_DIV cycles; FLASH_OFF lasts exactly OFF_TICKS×TICK_DIV cycles.
- **Sequence length.** (ON_TICKS+OFF_TICKS)×TICK_DIV×FLASH_COUNT cycles from the trigger edge to the HOLD entry edge. At the HOLD entry edge, busy falls and led_out becomes colour together.
- **new_game latency.** new_game sampled at edge m: outputs are at their IDLE values after edge m.
- **Degenerate parameters.** TICK_DIV=1: a tick occurs on every cycle in the flash states.

## Test plan
Parameters for all scenarios: TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, FLASH_COUNT=2.

- **Player-1 win.** Reset, then detect_win=01 held. Required:
  - led_out=100 for 8 cycles, then 000 for 4, then 100 for 8, then 000 for 4;
  - then led_out=100 steady;
  - busy=1 for exactly 24 cycles; result=01 throughout.
- **Draw, then new game.** detect_win=11 until HOLD, then a new_game pulse with detect_win still 11. Required:
  - led_out=001 during the flashes and the hold;
  - after new_game: led_out=000 and result=00;
  - no retrigger while detect_win=11;
  - detect_win→00 for one cycle, then 10 → player-2 sequence with led_out=010.
- **Abort mid-flash.** new_game asserted during the second FLASH_ON with detect_win=01 in the same cycle. Required: IDLE outputs on the next edge; no trigger in that cycle.
- **Input change ignored.** detect_win switches 01→10 during FLASH_OFF. Required: result stays 01 and the colour stays 100 through HOLD.
- **Asynchronous reset.** rst_n pulsed low between clock edges during FLASH_ON. Required: led_out=000, busy=0, result=00 before the next edge; the sequence restarts from the beginning after release while detect_win≠00.
